uart_rx_param: RTL

Parametrised UART receiver and successor to the fixed 8N1 receiver.
- Configurable data width, parity mode, stop-bit count and oversampling ratio.
- Two-flop input synchroniser, false-start rejection, and per-frame parity/framing error flags.
- Sits between the rx pin and the receive buffer; presents one word per frame with a single-cycle done strobe.

---
 rtl/uart_rx_param.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Purpose: parametrised UART receiver (data width, parity, stop bits, oversampling) with sync, false-start reject, error flags.
// Latency: ~2 + DIV*OVERSAMPLE*(0.5 + DATA_BITS + (PARITY!=0) + STOP_BITS) clocks from rx falling edge to rxDone.
// Backpressure: none; one word per frame with a single-cycle rxDone strobe, consumer must take it on that clock.
module uart_rx_param #(
  parameter int CLOCK_RATE = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] toBuffer,
  output logic                 rxDone,
  output logic                 parityErr,
  output logic                 frameErr,
  output logic                 busy
);

  localparam int DIV    = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int IDX_W  = $clog2(DATA_BITS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic              PAR_ODD   = (PARITY == 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  logic                 rxMeta;
  logic                 rxS;
  logic [DIV_W-1:0]     divCnt;
  logic [TICK_W-1:0]    tickCnt;
  logic [IDX_W-1:0]     bitIdx;
  logic                 stopCnt;
  logic [DATA_BITS-1:0] shift;
  logic                 perr;
  logic                 ferr;
  logic                 armed;

  logic tick;
  logic midStart;
  logic midBit;
  logic ferrNext;
  logic perrNext;

  // Divider only runs while a frame is in progress, so the first tick lands DIV clocks into START.
  assign tick     = (state != S_IDLE) && (divCnt == DIV_LAST);
  assign midStart = tick && (tickCnt == HALF_LAST);
  assign midBit   = tick && (tickCnt == BIT_LAST);
  // A low stop-bit sample is sticky across both stop bits.
  assign ferrNext = ferr | ~rxS;
  // Mismatch when data ones plus parity bit do not give the required odd/even total.
  assign perrNext = ((^shift) ^ rxS) != PAR_ODD;
  assign busy     = (state != S_IDLE);

  // Two-flop synchroniser; idles high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxS    <= rxMeta;
    end
  end

  // Baud tick divider, held at zero while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divCnt <= '0;
    end else if (state == S_IDLE || divCnt == DIV_LAST) begin
      divCnt <= '0;
    end else begin
      divCnt <= divCnt + 1'b1;
    end
  end

  // Frame FSM: start validation, mid-bit sampling, and registered result/flag update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      armed     <= 1'b1;
      tickCnt   <= '0;
      bitIdx    <= '0;
      stopCnt   <= 1'b0;
      shift     <= '0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      toBuffer  <= '0;
      rxDone    <= 1'b0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      rxDone <= 1'b0;
      if (tick) tickCnt <= tickCnt + 1'b1;
      case (state)
        S_IDLE: begin
          // Re-arm only after the line is seen high again (guards against a held-low break).
          if (rxS) armed <= 1'b1;
          if (armed && !rxS) begin
            state   <= S_START;
            tickCnt <= '0;
            bitIdx  <= '0;
            stopCnt <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
          end
        end
        S_START: begin
          if (midStart) begin
            tickCnt <= '0;
            state   <= rxS ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (midBit) begin
            tickCnt <= '0;
            // LSB arrives first; after DATA_BITS shifts it sits in bit 0.
            shift   <= {rxS, shift[DATA_BITS-1:1]};
            bitIdx  <= bitIdx + 1'b1;
            if (bitIdx == IDX_LAST) state <= (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (midBit) begin
            tickCnt <= '0;
            perr    <= perrNext;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (midBit) begin
            tickCnt <= '0;
            if (stopCnt == STOP_LAST) begin
              // Finish at mid stop bit so a back-to-back start edge is not missed.
              toBuffer  <= shift;
              parityErr <= perr;
              frameErr  <= ferrNext;
              rxDone    <= 1'b1;
              armed     <= ~ferrNext;
              state     <= S_IDLE;
            end else begin
              stopCnt <= 1'b1;
              ferr    <= ferrNext;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
